// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the matrix-multiply MAC sequencer.
// Optional build macro used by mac_seq_ctrl: MAC_SEQ_CTRL_PERF_EN.
package mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_READOUT = 3'd4,
      ST_DONE    = 3'd5
   } mac_state_t;

   // Address width that never collapses to zero bits for single-element buffers.
   function automatic int unsigned aw(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

   localparam int unsigned PM_DEF = 4;
   localparam int unsigned PK_DEF = 4;
   localparam int unsigned PN_DEF = 4;

   localparam int unsigned A_N = PM_DEF * PK_DEF;
   localparam int unsigned B_N = PK_DEF * PN_DEF;
   localparam int unsigned C_N = PM_DEF * PN_DEF;

   localparam int unsigned A_AW = aw(A_N);
   localparam int unsigned B_AW = aw(B_N);
   localparam int unsigned C_AW = aw(C_N);

endpackage

// File: rtl/mac_idx_counter.sv
// Nested i/j/k loop counter for the MAC sequencer; k is innermost, i outermost.
module mac_idx_counter
   import mac_pkg::*;
#(
   parameter int unsigned PM = 4,
   parameter int unsigned PK = 4,
   parameter int unsigned PN = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clear,
   input  logic               advance,
   output logic [aw(PM)-1:0]  i,
   output logic [aw(PN)-1:0]  j,
   output logic [aw(PK)-1:0]  k,
   output logic               first,
   output logic               last_k,
   output logic               last_all
);

   localparam int unsigned IW = aw(PM);
   localparam int unsigned JW = aw(PN);
   localparam int unsigned KW = aw(PK);

   logic last_j;
   logic last_i;

   assign first    = (k == '0);
   assign last_k   = (32'(k) == PK - 1);
   assign last_j   = (32'(j) == PN - 1);
   assign last_i   = (32'(i) == PM - 1);
   assign last_all = last_k & last_j & last_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (clear) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (advance) begin
         if (last_k) begin
            k <= '0;
            if (last_j) begin
               j <= '0;
               i <= last_i ? '0 : i + IW'(1);
            end else begin
               j <= j + JW'(1);
            end
         end else begin
            k <= k + KW'(1);
         end
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for C = A*B on the MAC datapath: load, issue i/j/k reads, write back C, read out.
// Optional cycle counter output is built only with MAC_SEQ_CTRL_PERF_EN defined.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int unsigned PM      = 4,
   parameter int unsigned PK      = 4,
   parameter int unsigned PN      = 4,
   parameter int unsigned MAC_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  a_b_we,
   output logic                  a_b_re,
   output logic [aw(PM*PK)-1:0]  a_addr,
   output logic [aw(PK*PN)-1:0]  b_addr,
   output logic                  mac_en,
   output logic                  mac_first,
   output logic                  c_we,
   output logic [aw(PM*PN)-1:0]  c_addr,
   output logic                  c_re,
   output mac_state_t            dbg_state
`ifdef MAC_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]           cycle_cnt
`endif
);

   localparam int unsigned AAW = aw(PM*PK);
   localparam int unsigned BAW = aw(PK*PN);
   localparam int unsigned CAW = aw(PM*PN);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] LOAD    = ST_LOAD;
   localparam logic [2:0] COMPUTE = ST_COMPUTE;
   localparam logic [2:0] DRAIN   = ST_DRAIN;
   localparam logic [2:0] READOUT = ST_READOUT;
   localparam logic [2:0] DONE    = ST_DONE;

   logic [2:0]          state;
   logic [aw(PM)-1:0]   ci;
   logic [aw(PN)-1:0]   cj;
   logic [aw(PK)-1:0]   ck;
   logic                cnt_first, cnt_last_k, cnt_last_all;
   logic                issue, issue_last, iss_first, iss_last_k, pend;
   logic [CAW-1:0]      iss_cidx;
   logic [MAC_LAT:0]    pipe_v;
   logic [CAW-1:0]      pipe_idx [MAC_LAT+1];

   assign dbg_state = mac_state_t'(state);
   assign issue     = (state == LOAD) || (state == COMPUTE && !issue_last);

   mac_idx_counter #(.PM(PM), .PK(PK), .PN(PN)) u_idx (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (state == IDLE),
      .advance  (issue),
      .i        (ci),
      .j        (cj),
      .k        (ck),
      .first    (cnt_first),
      .last_k   (cnt_last_k),
      .last_all (cnt_last_all)
   );

   // start is a level request with no handshake: it is honoured only in IDLE, never queued.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         a_b_we     <= 1'b0;
         a_b_re     <= 1'b0;
         c_re       <= 1'b0;
         a_addr     <= '0;
         b_addr     <= '0;
         iss_first  <= 1'b0;
         iss_last_k <= 1'b0;
         iss_cidx   <= '0;
         issue_last <= 1'b0;
      end else begin
         a_b_we <= 1'b0;
         a_b_re <= 1'b0;
         c_re   <= 1'b0;
         done   <= 1'b0;
         if (issue) begin
            a_b_re     <= 1'b1;
            a_addr     <= AAW'(32'(ci) * PK + 32'(ck));
            b_addr     <= BAW'(32'(ck) * PN + 32'(cj));
            iss_cidx   <= CAW'(32'(ci) * PN + 32'(cj));
            iss_first  <= cnt_first;
            iss_last_k <= cnt_last_k;
            issue_last <= cnt_last_all;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= LOAD;
                  a_b_we <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            LOAD:    state <= COMPUTE;
            COMPUTE: if (issue_last) state <= DRAIN;
            DRAIN: begin
               if (!pend) begin
                  c_re  <= 1'b1;
                  state <= READOUT;
               end
            end
            READOUT: begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Stage 0 lines up with mac_en; the write fires when the entry reaches stage MAC_LAT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mac_en    <= 1'b0;
         mac_first <= 1'b0;
         pipe_v    <= '0;
         for (int s = 0; s <= MAC_LAT; s++) pipe_idx[s] <= '0;
      end else begin
         mac_en      <= a_b_re;
         mac_first   <= a_b_re & iss_first;
         pipe_v      <= {pipe_v[MAC_LAT-1:0], a_b_re & iss_last_k};
         pipe_idx[0] <= iss_cidx;
         for (int s = 1; s <= MAC_LAT; s++) pipe_idx[s] <= pipe_idx[s-1];
      end
   end

   always_comb begin
      pend = 1'b0;
      for (int s = 0; s < MAC_LAT; s++) pend = pend | pipe_v[s];
   end

   assign c_we   = pipe_v[MAC_LAT];
   assign c_addr = pipe_idx[MAC_LAT];

`ifdef MAC_SEQ_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt <= '0;
      end else if (state == IDLE && start) begin
         cycle_cnt <= '0;
      end else if (busy && cycle_cnt != '1) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: three configurations, scoreboard of timed strobes, and an A=I end-to-end data check.
module tb_mac_seq_ctrl;
   import mac_pkg::*;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic [2:0] start = '0;
   int         cyc = 0;
   int         sel = 0;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] busy, done, a_b_we, a_b_re, mac_en, mac_first, c_we, c_re;
   logic [3:0] a_addr0, b_addr0, c_addr0, c_addr2;
   logic [1:0] a_addr1, b_addr1, c_addr1, a_addr2, b_addr2;
   mac_state_t st0, st1, st2;
`ifdef MAC_SEQ_CTRL_PERF_EN
   logic [31:0] ccnt0, ccnt1, ccnt2;
`endif

   mac_seq_ctrl #(.PM(4), .PK(4), .PN(4), .MAC_LAT(1)) u_d0 (
      .clk(clk), .rstn(rstn), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .a_b_we(a_b_we[0]), .a_b_re(a_b_re[0]), .a_addr(a_addr0), .b_addr(b_addr0),
      .mac_en(mac_en[0]), .mac_first(mac_first[0]), .c_we(c_we[0]), .c_addr(c_addr0),
      .c_re(c_re[0]), .dbg_state(st0)
`ifdef MAC_SEQ_CTRL_PERF_EN
      , .cycle_cnt(ccnt0)
`endif
   );

   mac_seq_ctrl #(.PM(2), .PK(2), .PN(2), .MAC_LAT(1)) u_d1 (
      .clk(clk), .rstn(rstn), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .a_b_we(a_b_we[1]), .a_b_re(a_b_re[1]), .a_addr(a_addr1), .b_addr(b_addr1),
      .mac_en(mac_en[1]), .mac_first(mac_first[1]), .c_we(c_we[1]), .c_addr(c_addr1),
      .c_re(c_re[1]), .dbg_state(st1)
`ifdef MAC_SEQ_CTRL_PERF_EN
      , .cycle_cnt(ccnt1)
`endif
   );

   mac_seq_ctrl #(.PM(4), .PK(1), .PN(4), .MAC_LAT(3)) u_d2 (
      .clk(clk), .rstn(rstn), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .a_b_we(a_b_we[2]), .a_b_re(a_b_re[2]), .a_addr(a_addr2), .b_addr(b_addr2),
      .mac_en(mac_en[2]), .mac_first(mac_first[2]), .c_we(c_we[2]), .c_addr(c_addr2),
      .c_re(c_re[2]), .dbg_state(st2)
`ifdef MAC_SEQ_CTRL_PERF_EN
      , .cycle_cnt(ccnt2)
`endif
   );

   int cfg_pm [3] = '{4, 2, 4};
   int cfg_pk [3] = '{4, 2, 1};
   int cfg_pn [3] = '{4, 2, 4};
   int cfg_l  [3] = '{1, 1, 3};

   // Selected-instance view for the monitor.
   logic       m_busy, m_done, m_we, m_re, m_mac, m_first, m_cwe, m_cre;
   logic [7:0] m_a, m_b, m_c;
   always_comb begin
      m_busy  = busy[sel];
      m_done  = done[sel];
      m_we    = a_b_we[sel];
      m_re    = a_b_re[sel];
      m_mac   = mac_en[sel];
      m_first = mac_first[sel];
      m_cwe   = c_we[sel];
      m_cre   = c_re[sel];
      case (sel)
         1: begin m_a = 8'(a_addr1); m_b = 8'(b_addr1); m_c = 8'(c_addr1); end
         2: begin m_a = 8'(a_addr2); m_b = 8'(b_addr2); m_c = 8'(c_addr2); end
         default: begin m_a = 8'(a_addr0); m_b = 8'(b_addr0); m_c = 8'(c_addr0); end
      endcase
   end

   // Scoreboard: entries are {cycle, payload}, pushed at launch, popped when the strobe appears.
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_mac_q[$];
   logic [31:0] exp_cw_q[$];
   logic [31:0] exp_we_q[$];
   logic [31:0] exp_re_q[$];
   logic [31:0] exp_done_q[$];
   bit          exp_busy [8192];

   // Memory unit and MAC stand-in driven by instance 0.
   logic [7:0]  in_a [16];
   logic [7:0]  in_b [16];
   logic [7:0]  mem_a [16];
   logic [7:0]  mem_b [16];
   logic [15:0] mem_c [16];
   logic [15:0] dout [16];
   logic [7:0]  a_q, b_q;
   logic [15:0] acc;

   always @(posedge clk) begin
      if (a_b_we[0]) for (int x = 0; x < 16; x++) begin
         mem_a[x] <= in_a[x];
         mem_b[x] <= in_b[x];
      end
      if (a_b_re[0]) begin
         a_q <= mem_a[a_addr0];
         b_q <= mem_b[b_addr0];
      end
      if (mac_en[0]) acc <= mac_first[0] ? 16'(a_q) * 16'(b_q) : acc + 16'(a_q) * 16'(b_q);
      if (c_we[0]) mem_c[c_addr0] <= acc;
      if (c_re[0]) for (int x = 0; x < 16; x++) dout[x] <= mem_c[x];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_job(input int s);
      int pm, pk, pn, l, n, idx;
      pm = cfg_pm[sel]; pk = cfg_pk[sel]; pn = cfg_pn[sel]; l = cfg_l[sel];
      n = pm * pk * pn;
      exp_we_q.push_back(32'(s + 1));
      for (int i = 0; i < pm; i++)
         for (int j = 0; j < pn; j++)
            for (int k = 0; k < pk; k++) begin
               idx = (i * pn + j) * pk + k;
               exp_rd_q.push_back({16'(s + 2 + idx), 8'(i * pk + k), 8'(k * pn + j)});
               exp_mac_q.push_back({16'(s + 3 + idx), 15'd0, (k == 0)});
               if (k == pk - 1) exp_cw_q.push_back({16'(s + 3 + idx + l), 16'(i * pn + j)});
            end
      exp_re_q.push_back(32'(s + n + 3 + l));
      exp_done_q.push_back(32'(s + n + 4 + l));
      for (int c = s + 1; c <= s + n + 4 + l; c++) exp_busy[c] = 1'b1;
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (rstn) begin
         check("busy", 32'(m_busy), 32'(exp_busy[cyc]));
         check("c_we_with_c_re", 32'(m_cwe & m_cre), 32'd0);
         check("a_b_we_overlap", 32'(m_we & (m_re | m_mac | m_cwe | m_cre | m_done)), 32'd0);
         if (m_we) begin
            if (exp_we_q.size() > 0) e = exp_we_q.pop_front(); else e = '1;
            check("a_b_we_cycle", 32'(cyc), e);
         end
         if (m_re) begin
            if (exp_rd_q.size() > 0) e = exp_rd_q.pop_front(); else e = '1;
            check("read_cyc_a_b", {16'(cyc), m_a, m_b}, e);
         end
         if (m_mac) begin
            if (exp_mac_q.size() > 0) e = exp_mac_q.pop_front(); else e = '1;
            check("mac_cyc_first", {16'(cyc), 15'd0, m_first}, e);
         end
         if (m_cwe) begin
            if (exp_cw_q.size() > 0) e = exp_cw_q.pop_front(); else e = '1;
            check("c_we_cyc_addr", {16'(cyc), 8'd0, m_c}, e);
         end
         if (m_cre) begin
            if (exp_re_q.size() > 0) e = exp_re_q.pop_front(); else e = '1;
            check("c_re_cycle", 32'(cyc), e);
         end
         if (m_done) begin
            if (exp_done_q.size() > 0) e = exp_done_q.pop_front(); else e = '1;
            check("done_cycle", 32'(cyc), e);
            if (sel == 0) begin
               for (int x = 0; x < 16; x++) check("c_data", 32'(dout[x]), 32'(in_b[x]));
`ifdef MAC_SEQ_CTRL_PERF_EN
               check("cycle_cnt", ccnt0, 32'd68);
`endif
            end
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input int inst, input bit hold, output int s);
      sel = inst;
      if (inst == 0) for (int x = 0; x < 16; x++) in_b[x] = 8'($urandom_range(1, 200));
      start[inst] = 1'b1;
      s = cyc;
      push_job(s);
      @(posedge clk);
      #1;
      if (!hold) start[inst] = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy[sel] || exp_done_q.size() > 0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_within_budget", 32'(n < budget), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) in_a[r * 4 + c] = (r == c) ? 8'd1 : 8'd0;
      for (int x = 0; x < 16; x++) in_b[x] = 8'(x + 1);

      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", {8'd0, busy, done, a_b_we, a_b_re, mac_en, mac_first, c_we, c_re}, 32'd0);
      check("rst_addr0", {20'd0, a_addr0, b_addr0, c_addr0}, 32'd0);
      check("rst_addr12", {18'd0, a_addr1, b_addr1, c_addr1, a_addr2, b_addr2, c_addr2}, 32'd0);
      check("rst_state", {23'd0, st0, st1, st2}, {23'd0, ST_IDLE, ST_IDLE, ST_IDLE});
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Default 4x4x4 job, A = identity, random B.
      launch(0, 1'b0, s);
      wait_idle(200);

      // 2x2x2 and PK=1 / MAC_LAT=3 configurations.
      launch(1, 1'b0, s);
      wait_idle(100);
      launch(2, 1'b0, s);
      wait_idle(100);

      // start pulsed during COMPUTE and DRAIN must be ignored.
      launch(0, 1'b0, s);
      goto(s + 30);
      check("state_compute", 32'(st0), 32'(ST_COMPUTE));
      start[0] = 1'b1;
      goto(s + 31);
      start[0] = 1'b0;
      goto(s + 66);
      check("state_drain", 32'(st0), 32'(ST_DRAIN));
      start[0] = 1'b1;
      goto(s + 67);
      start[0] = 1'b0;
      wait_idle(200);

      // start held high relaunches on the IDLE cycle that follows DONE.
      launch(0, 1'b1, s);
      push_job(s + 70);
      goto(s + 71);
      start[0] = 1'b0;
      wait_idle(300);

      // Reset in the middle of a job, then a clean restart.
      launch(0, 1'b0, s);
      goto(s + 20);
      rstn = 1'b0;
      exp_rd_q.delete();
      exp_mac_q.delete();
      exp_cw_q.delete();
      exp_we_q.delete();
      exp_re_q.delete();
      exp_done_q.delete();
      for (int c = cyc; c < 8192; c++) exp_busy[c] = 1'b0;
      #1;
      check("midrst_strobes", {24'd0, busy[0], done[0], a_b_we[0], a_b_re[0], mac_en[0],
                               mac_first[0], c_we[0], c_re[0]}, 32'd0);
      check("midrst_addr", {20'd0, a_addr0, b_addr0, c_addr0}, 32'd0);
      check("midrst_state", 32'(st0), 32'(ST_IDLE));
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      launch(0, 1'b0, s);
      wait_idle(200);

      check("leftover_expected", 32'(exp_rd_q.size() + exp_mac_q.size() + exp_cw_q.size() +
                                     exp_we_q.size() + exp_re_q.size() + exp_done_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
